// File: rtl/fir_serial_mac_if.sv
// Sample/coefficient/FIFO-write bundle for fir_serial_mac.
// The slave modport is the filter side; the master modport is the producer/FIFO side.
interface fir_serial_mac_if #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8
);
    localparam int AW = $clog2(TAPS);

    logic                  i_valid;
    logic [WIDTH-1:0]      i_data;
    logic                  o_ready;
    logic                  i_coef_we;
    logic [AW-1:0]         i_coef_addr;
    logic [COEF_WIDTH-1:0] i_coef_data;
    logic                  o_busy;
    logic                  o_wren;
    logic [WIDTH-1:0]      o_wdata;
    logic                  i_full;

    modport slave (
        input  i_valid, i_data, i_coef_we, i_coef_addr, i_coef_data, i_full,
        output o_ready, o_busy, o_wren, o_wdata
    );

    modport master (
        output i_valid, i_data, i_coef_we, i_coef_addr, i_coef_data, i_full,
        input  o_ready, o_busy, o_wren, o_wdata
    );
endinterface

// File: rtl/fir_serial_mac.sv
// Single-multiplier serial FIR feeding an async FIFO write port, with runtime coefficients.
// FIR_SAT_EN defined: output saturates to WIDTH; undefined: output wraps to its low WIDTH bits.
module fir_serial_mac #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int ACC_WIDTH  = WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic             i_wrclk,
    input  logic             i_wrstn,
    fir_serial_mac_if.slave  bus
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] RND_C =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEF_WIDTH-2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS-1);
    localparam logic [IDX_W:0]   ADDR_LIM = (IDX_W+1)'(TAPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic signed [WIDTH-1:0]       x_q [TAPS];
    logic signed [WIDTH-1:0]       x_d [TAPS];
    logic signed [COEF_WIDTH-1:0]  h_q [TAPS];
    logic signed [COEF_WIDTH-1:0]  h_d [TAPS];
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [WIDTH-1:0]              wdata_q, wdata_d;
    logic signed [PROD_W-1:0]      x_ext_s, h_ext_s, prod_s;
    logic                          accept_s, coef_wr_s;
    logic                          ready_s, busy_s, wren_s;

`ifdef FIR_SAT_EN
    // Clamp when the bits above the sign position disagree (value out of range).
    function automatic logic [WIDTH-1:0] fit_f(input logic signed [ACC_WIDTH-1:0] r);
        logic [WIDTH-1:0] res;
        if ((&r[ACC_WIDTH-1:WIDTH-1]) || !(|r[ACC_WIDTH-1:WIDTH-1])) begin
            res = r[WIDTH-1:0];
        end else if (r[ACC_WIDTH-1]) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return res;
    endfunction
`endif

    assign accept_s  = (state_q == ST_IDLE) && bus.i_valid;
    assign coef_wr_s = (state_q == ST_IDLE) && bus.i_coef_we &&
                       ({1'b0, bus.i_coef_addr} < ADDR_LIM);

    // FSM state register.
    always_ff @(posedge i_wrclk or negedge i_wrstn) begin
        if (!i_wrstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_MAC;
                else          state_d = ST_IDLE;
            end
            ST_MAC: begin
                if (idx_q == IDX_LAST) state_d = ST_ROUND;
                else                   state_d = ST_MAC;
            end
            ST_ROUND: state_d = ST_PUSH;
            ST_PUSH: begin
                if (!bus.i_full) state_d = ST_IDLE;
                else             state_d = ST_PUSH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the FIFO write strobe follows full combinationally so no push is lost.
    always_comb begin
        ready_s = (state_q == ST_IDLE);
        busy_s  = (state_q != ST_IDLE);
        wren_s  = (state_q == ST_PUSH) && !bus.i_full;
    end

    assign bus.o_ready = ready_s;
    assign bus.o_busy  = busy_s;
    assign bus.o_wren  = wren_s;
    assign bus.o_wdata = wdata_q;

    // Datapath next-state: delay line, coefficient bank, serial MAC and rounding.
    always_comb begin
        x_d     = x_q;
        h_d     = h_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        x_ext_s = {{COEF_WIDTH{x_q[idx_q][WIDTH-1]}}, x_q[idx_q]};
        h_ext_s = {{WIDTH{h_q[idx_q][COEF_WIDTH-1]}}, h_q[idx_q]};
        prod_s  = x_ext_s * h_ext_s;

        if (coef_wr_s) begin
            h_d[bus.i_coef_addr] = bus.i_coef_data;
        end else begin
            h_d = h_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    x_d[0] = bus.i_data;
                    for (int k = 1; k < TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    acc_d = '0;
                    idx_d = '0;
                end else begin
                    x_d = x_q;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
                if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
                else                   idx_d = idx_q;
            end
            ST_ROUND: begin
`ifdef FIR_SAT_EN
                wdata_d = fit_f((acc_q + RND_C) >>> (COEF_WIDTH-1));
`else
                wdata_d = WIDTH'((acc_q + RND_C) >>> (COEF_WIDTH-1));
`endif
            end
            ST_PUSH: wdata_d = wdata_q;
            default: wdata_d = wdata_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_wrclk or negedge i_wrstn) begin
        if (!i_wrstn) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
            end
            acc_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomized self-checking bench for fir_serial_mac (TAPS=4, 16-bit samples and coefficients).
// Expected outputs come from a plain-arithmetic convolution model kept in the bench.
module tb_fir_serial_mac;
    localparam int W   = 16;
    localparam int CW  = 16;
    localparam int T   = 4;
    localparam int LAT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_serial_mac_if #(.WIDTH(W), .COEF_WIDTH(CW), .TAPS(T)) bus_if ();

    fir_serial_mac #(.WIDTH(W), .COEF_WIDTH(CW), .TAPS(T)) dut (
        .i_wrclk (clk),
        .i_wrstn (rst_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] x_m [T];
    logic signed [15:0] h_m [T];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < T; k++) begin
            x_m[k] = 16'sd0;
            h_m[k] = 16'sd0;
        end
    endtask

    function automatic logic [15:0] model_out();
        longint acc;
        longint r;
        acc = 64'sd0;
        for (int k = 0; k < T; k++) acc += longint'(x_m[k]) * longint'(h_m[k]);
        r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
        if (r > 64'sd32767)       return 16'h7FFF;
        else if (r < -64'sd32768) return 16'h8000;
        else                      return r[15:0];
`else
        return r[15:0];
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus_if.o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_wait", 32'(bus_if.o_ready), 32'd1);
    endtask

    task automatic coef_write(input logic [1:0] addr, input logic [15:0] data);
        wait_ready();
        bus_if.i_coef_we   = 1'b1;
        bus_if.i_coef_addr = addr;
        bus_if.i_coef_data = data;
        @(posedge clk); #1;
        bus_if.i_coef_we = 1'b0;
        h_m[addr] = data;
    endtask

    // junk: 0 none, 1 random valid/coef writes while busy, 2 fixed h[0]=0x7FFF write while busy
    task automatic run_sample(input logic [15:0] din, input int full_cyc, input int junk,
                              input bit cw, input logic [1:0] caddr, input logic [15:0] cdata);
        logic [15:0] exp_v;
        int cyc;
        bit seen;
        wait_ready();
        bus_if.i_valid = 1'b1;
        bus_if.i_data  = din;
        if (cw) begin
            bus_if.i_coef_we   = 1'b1;
            bus_if.i_coef_addr = caddr;
            bus_if.i_coef_data = cdata;
        end
        @(posedge clk); #1;
        bus_if.i_valid   = 1'b0;
        bus_if.i_coef_we = 1'b0;
        if (cw) h_m[caddr] = cdata;
        for (int k = T-1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = din;
        exp_v = model_out();
        check_eq("busy_after_accept", 32'(bus_if.o_busy), 32'd1);
        check_eq("ready_after_accept", 32'(bus_if.o_ready), 32'd0);
        bus_if.i_full = (full_cyc > 0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < LAT + full_cyc + 20) begin
            @(posedge clk); #1;
            cyc++;
            bus_if.i_full = (full_cyc > 0) && (cyc < LAT + full_cyc);
            if (junk == 1) begin
                bus_if.i_valid     = 1'($urandom_range(0, 1));
                bus_if.i_data      = 16'($urandom);
                bus_if.i_coef_we   = 1'($urandom_range(0, 1));
                bus_if.i_coef_addr = 2'($urandom_range(0, 3));
                bus_if.i_coef_data = 16'($urandom);
            end else if (junk == 2) begin
                bus_if.i_valid     = 1'b1;
                bus_if.i_data      = 16'h1234;
                bus_if.i_coef_we   = 1'b1;
                bus_if.i_coef_addr = 2'd0;
                bus_if.i_coef_data = 16'h7FFF;
            end
            #1;
            if (bus_if.o_wren) begin
                seen = 1'b1;
            end else if (cyc >= LAT && full_cyc > 0) begin
                check_eq("ready_while_full", 32'(bus_if.o_ready), 32'd0);
                check_eq("wdata_held", 32'(bus_if.o_wdata), 32'(exp_v));
            end
        end
        bus_if.i_valid   = 1'b0;
        bus_if.i_coef_we = 1'b0;
        bus_if.i_full    = 1'b0;
        check_eq("wren_seen", 32'(seen), 32'd1);
        check_eq("wren_latency", 32'(cyc), 32'(LAT + full_cyc));
        check_eq("wdata", 32'(bus_if.o_wdata), 32'(exp_v));
        @(posedge clk); #1;
        check_eq("wren_single_pulse", 32'(bus_if.o_wren), 32'd0);
        check_eq("ready_after_push", 32'(bus_if.o_ready), 32'd1);
    endtask

    initial begin
        bus_if.i_valid     = 1'b0;
        bus_if.i_data      = 16'h0000;
        bus_if.i_coef_we   = 1'b0;
        bus_if.i_coef_addr = 2'd0;
        bus_if.i_coef_data = 16'h0000;
        bus_if.i_full      = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(bus_if.o_ready), 32'd1);
        check_eq("rst_wren",  32'(bus_if.o_wren),  32'd0);
        check_eq("rst_wdata", 32'(bus_if.o_wdata), 32'd0);
        check_eq("rst_busy",  32'(bus_if.o_busy),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse response through half-scale coefficients.
        for (int k = 0; k < T; k++) coef_write(2'(k), 16'h4000);
        run_sample(16'h7FFF, 0, 0, 1'b0, 2'd0, 16'h0000);
        check_eq("impulse_first", 32'(bus_if.o_wdata), 32'h4000);
        for (int k = 0; k < 5; k++) run_sample(16'h0000, 0, 0, 1'b0, 2'd0, 16'h0000);
        check_eq("impulse_tail", 32'(bus_if.o_wdata), 32'h0000);

        // Full-scale positive and negative overload.
        for (int k = 0; k < T; k++) coef_write(2'(k), 16'h7FFF);
        for (int k = 0; k < T; k++) run_sample(16'h7FFF, 0, 0, 1'b0, 2'd0, 16'h0000);
`ifdef FIR_SAT_EN
        check_eq("pos_overload", 32'(bus_if.o_wdata), 32'h7FFF);
`else
        check_eq("pos_overload", 32'(bus_if.o_wdata), 32'hFFF8);
`endif
        for (int k = 0; k < T; k++) run_sample(16'h8000, 0, 0, 1'b0, 2'd0, 16'h0000);
`ifdef FIR_SAT_EN
        check_eq("neg_overload", 32'(bus_if.o_wdata), 32'h8000);
`else
        check_eq("neg_overload", 32'(bus_if.o_wdata), 32'h0004);
`endif

        // FIFO full held for 10 cycles in PUSH.
        run_sample(16'h1234, 10, 0, 1'b0, 2'd0, 16'h0000);

        // Coefficient write while busy is dropped; together with accept it is used.
        for (int k = 0; k < T; k++) coef_write(2'(k), 16'h4000);
        for (int k = 0; k < T; k++) run_sample(16'h0000, 0, 0, 1'b0, 2'd0, 16'h0000);
        run_sample(16'h7FFF, 0, 2, 1'b0, 2'd0, 16'h0000);
        for (int k = 0; k < T; k++) run_sample(16'h0000, 0, 0, 1'b0, 2'd0, 16'h0000);
        run_sample(16'h7FFF, 0, 0, 1'b0, 2'd0, 16'h0000);
        check_eq("busy_write_dropped", 32'(bus_if.o_wdata), 32'h4000);
        for (int k = 0; k < T; k++) run_sample(16'h0000, 0, 0, 1'b0, 2'd0, 16'h0000);
        run_sample(16'h7FFF, 0, 0, 1'b1, 2'd0, 16'h7FFF);
        check_eq("idle_write_with_accept", 32'(bus_if.o_wdata), 32'h7FFE);

        // Randomized traffic with busy-time noise and occasional backpressure.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) coef_write(2'($urandom_range(0, 3)), 16'($urandom));
            run_sample(16'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                       1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Reset in the second MAC cycle.
        wait_ready();
        bus_if.i_valid = 1'b1;
        bus_if.i_data  = 16'h7FFF;
        @(posedge clk); #1;
        bus_if.i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_wren",  32'(bus_if.o_wren),  32'd0);
        check_eq("midrst_ready", 32'(bus_if.o_ready), 32'd1);
        check_eq("midrst_busy",  32'(bus_if.o_busy),  32'd0);
        check_eq("midrst_wdata", 32'(bus_if.o_wdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        run_sample(16'h7FFF, 0, 0, 1'b0, 2'd0, 16'h0000);
        check_eq("post_rst_impulse", 32'(bus_if.o_wdata), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
